pixel_arbiter: RTL

Downstream consumer of the sprite (blob) stages. Once per 25 MHz pixel slot it samples up to N_SPRITES one-cycle read requests and picks the winner by layer priority. It then reads the winner's pixel from the shared sprite BRAM and drives one registered colour (or the background colour) to the VGA output stage, aligned with a delayed blank.

---
 rtl/pixel_arbiter.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/pixel_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | pixel_arbiter : per-pixel-slot layer arbiter; fetches the winning sprite's |
// | pixel from the shared BRAM and drives a registered colour plus blank.      |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
module pixel_arbiter #(
  parameter int N_SPRITES     = 4,
  parameter int ram_add_width = 8,
  parameter int pixel_width   = 12,
  parameter int IDX_W         = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic                               clk25en,
  input  logic [N_SPRITES-1:0]               req,
  input  logic [N_SPRITES*ram_add_width-1:0] addr_bus,
  input  logic [2*N_SPRITES-1:0]             layer_bus,
  input  logic [pixel_width-1:0]             bg_color,
  input  logic                               blank_in,
  output logic                               bram_en,
  output logic [ram_add_width-1:0]           bram_addr,
  input  logic [pixel_width-1:0]             bram_rdata,
  output logic [pixel_width-1:0]             pixel_out,
  output logic                               blank_out,
  output logic                               grant_valid,
  output logic [IDX_W-1:0]                   grant_idx,
  output logic                               req_misaligned
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_C0   = 3'd1;
  localparam logic [2:0] S_C1   = 3'd2;
  localparam logic [2:0] S_C2   = 3'd3;
  localparam logic [2:0] S_C3   = 3'd4;

  // state_q holds the phase the next cycle will have unless a strobe restarts it.
  logic [2:0] state_q;
  logic [2:0] state_d;
  logic [2:0] phase;

  logic in_c0;
  logic in_c1;
  logic in_c3;

  logic                     arb_hit;
  logic [1:0]               arb_layer;
  logic [IDX_W-1:0]         arb_idx;
  logic [ram_add_width-1:0] arb_addr;

  logic                     blank_pend_q, blank_pend_d;
  logic                     hit_q, hit_d;
  logic [IDX_W-1:0]         win_idx_q, win_idx_d;
  logic                     bram_en_q, bram_en_d;
  logic [ram_add_width-1:0] bram_addr_q, bram_addr_d;
  logic [pixel_width-1:0]   pixel_q, pixel_d;
  logic                     blank_out_q, blank_out_d;
  logic                     gvalid_q, gvalid_d;
  logic [IDX_W-1:0]         gidx_q, gidx_d;
  logic                     mis_q, mis_d;

  assign phase = clk25en ? S_C0 : state_q;

  // Phase state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-phase logic
  always_comb begin
    state_d = S_IDLE;
    case (phase)
      S_C0:    state_d = S_C1;
      S_C1:    state_d = S_C2;
      S_C2:    state_d = S_C3;
      default: state_d = S_IDLE;
    endcase
  end

  // Phase decode
  always_comb begin
    in_c0 = 1'b0;
    in_c1 = 1'b0;
    in_c3 = 1'b0;
    case (phase)
      S_C0:    in_c0 = 1'b1;
      S_C1:    in_c1 = 1'b1;
      S_C3:    in_c3 = 1'b1;
      default: ;
    endcase
  end

  // Highest layer wins; strict compare keeps the lowest index on ties.
  always_comb begin
    arb_hit   = 1'b0;
    arb_layer = 2'd0;
    arb_idx   = '0;
    arb_addr  = '0;
    for (int i = 0; i < N_SPRITES; i++) begin
      if (req[i] && (!arb_hit || (layer_bus[2*i +: 2] > arb_layer))) begin
        arb_hit   = 1'b1;
        arb_layer = layer_bus[2*i +: 2];
        arb_idx   = i[IDX_W-1:0];
        arb_addr  = addr_bus[i*ram_add_width +: ram_add_width];
      end
    end
  end

  always_comb begin
    blank_pend_d = blank_pend_q;
    hit_d        = hit_q;
    win_idx_d    = win_idx_q;
    bram_en_d    = 1'b0;
    bram_addr_d  = bram_addr_q;
    pixel_d      = pixel_q;
    blank_out_d  = blank_out_q;
    gvalid_d     = gvalid_q;
    gidx_d       = gidx_q;
    mis_d        = mis_q | ((|req) & ~in_c1);

    if (in_c0) begin
      blank_pend_d = blank_in;
    end

    if (in_c1) begin
      hit_d     = arb_hit;
      win_idx_d = arb_idx;
      bram_en_d = arb_hit;
      if (arb_hit) begin
        bram_addr_d = arb_addr;
      end
    end

    // BRAM data for the fetch issued in C2 is valid throughout C3.
    if (in_c3) begin
      if (blank_pend_q) begin
        pixel_d = '0;
      end else if (hit_q) begin
        pixel_d = bram_rdata;
      end else begin
        pixel_d = bg_color;
      end
      blank_out_d = blank_pend_q;
      gvalid_d    = hit_q & ~blank_pend_q;
      gidx_d      = hit_q ? win_idx_q : '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      blank_pend_q <= 1'b1;
      hit_q        <= 1'b0;
      win_idx_q    <= '0;
      bram_en_q    <= 1'b0;
      bram_addr_q  <= '0;
      pixel_q      <= '0;
      blank_out_q  <= 1'b1;
      gvalid_q     <= 1'b0;
      gidx_q       <= '0;
      mis_q        <= 1'b0;
    end else begin
      blank_pend_q <= blank_pend_d;
      hit_q        <= hit_d;
      win_idx_q    <= win_idx_d;
      bram_en_q    <= bram_en_d;
      bram_addr_q  <= bram_addr_d;
      pixel_q      <= pixel_d;
      blank_out_q  <= blank_out_d;
      gvalid_q     <= gvalid_d;
      gidx_q       <= gidx_d;
      mis_q        <= mis_d;
    end
  end

  assign bram_en        = bram_en_q;
  assign bram_addr      = bram_addr_q;
  assign pixel_out      = pixel_q;
  assign blank_out      = blank_out_q;
  assign grant_valid    = gvalid_q;
  assign grant_idx      = gidx_q;
  assign req_misaligned = mis_q;

endmodule
`default_nettype wire
